// File: rtl/rx_fifo_arbiter_if.sv
// Receiver-channel FIFO taps and the merged downstream write port of rx_fifo_arbiter.
// master = arbiter side, slave = receiver FIFOs / output FIFO side.
interface rx_fifo_arbiter_if #(
    parameter int CHANNELS = 4,
    parameter int DSIZE    = 32
);
    logic [CHANNELS-1:0]       CHANNEL_EN;
    logic [CHANNELS-1:0]       RX_FIFO_EMPTY;
    logic [CHANNELS*DSIZE-1:0] RX_FIFO_DATA;
    logic [CHANNELS-1:0]       RX_FIFO_READ;
    logic                      OUT_FIFO_FULL;
    logic                      OUT_FIFO_WRITE;
    logic [DSIZE-1:0]          OUT_FIFO_DATA;
    logic [CHANNELS-1:0]       GRANT;
    logic [31:0]               WORD_CNT;

    modport master (
        input  CHANNEL_EN, RX_FIFO_EMPTY, RX_FIFO_DATA, OUT_FIFO_FULL,
        output RX_FIFO_READ, OUT_FIFO_WRITE, OUT_FIFO_DATA, GRANT, WORD_CNT
    );

    modport slave (
        output CHANNEL_EN, RX_FIFO_EMPTY, RX_FIFO_DATA, OUT_FIFO_FULL,
        input  RX_FIFO_READ, OUT_FIFO_WRITE, OUT_FIFO_DATA, GRANT, WORD_CNT
    );
endinterface

// File: rtl/rx_fifo_arbiter.sv
// Round-robin merge of CHANNELS first-word-fall-through receiver FIFOs, at most MAX_BURST words per grant.
// Latency: grant one cycle after a request, downstream write one cycle after each pop.
// Backpressure: OUT_FIFO_FULL with the output register occupied stalls pops; the grant is held.
module rx_fifo_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 8,
    parameter int DSIZE     = 32
) (
    input  logic            BUS_CLK,
    input  logic            BUS_RST,
    rx_fifo_arbiter_if.master bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);

    typedef enum logic {IDLE, SERVE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       last_grant_q, last_grant_d;
    logic [BW-1:0]       burst_cnt_q, burst_cnt_d;
    logic [CHANNELS-1:0] grant_q, grant_d;
    logic [CHANNELS-1:0] req, rd;
    logic [CW-1:0]       sel;
    logic                sel_vld;
    logic                pop, wr, can_accept;
    logic                g_empty, g_en;
    logic [DSIZE-1:0]    pop_dat;
    logic                out_valid_q;
    logic [DSIZE-1:0]    out_dat_q;
    logic [31:0]         word_cnt_q;

    assign req        = ~bus.RX_FIFO_EMPTY & bus.CHANNEL_EN;
    assign wr         = out_valid_q & ~bus.OUT_FIFO_FULL;
    assign can_accept = ~out_valid_q | ~bus.OUT_FIFO_FULL;
    // last_grant_q doubles as the index of the channel being served
    assign g_empty    = bus.RX_FIFO_EMPTY[last_grant_q];
    assign g_en       = bus.CHANNEL_EN[last_grant_q];
    assign pop_dat    = bus.RX_FIFO_DATA[int'(last_grant_q)*DSIZE +: DSIZE];

    // Scan from the farthest offset down so the nearest requester after last_grant wins
    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        for (int k = CHANNELS; k >= 1; k--) begin
            if (req[(int'(last_grant_q) + k) % CHANNELS]) begin
                sel     = CW'((int'(last_grant_q) + k) % CHANNELS);
                sel_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        pop          = 1'b0;
        rd           = '0;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d      = SERVE;
                    grant_d      = ONE_HOT0 << sel;
                    last_grant_d = sel;
                    burst_cnt_d  = '0;
                end
            end
            SERVE: begin
                pop = ~g_empty & g_en & (burst_cnt_q < BW'(MAX_BURST)) & can_accept;
                if (pop) begin
                    rd          = ONE_HOT0 << last_grant_q;
                    burst_cnt_d = burst_cnt_q + 1'b1;
                    if (burst_cnt_q == BW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end else if (g_empty || !g_en) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= CW'(CHANNELS - 1);
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Single-entry output register: a pop refills it in the same cycle it drains
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            if (pop) begin
                out_valid_q <= 1'b1;
                out_dat_q   <= pop_dat;
            end else if (wr) begin
                out_valid_q <= 1'b0;
            end
            if (wr) begin
                word_cnt_q <= word_cnt_q + 32'd1;
            end
        end
    end

    assign bus.RX_FIFO_READ   = rd;
    assign bus.OUT_FIFO_WRITE = wr;
    assign bus.OUT_FIFO_DATA  = out_dat_q;
    assign bus.GRANT          = grant_q;
    assign bus.WORD_CNT       = word_cnt_q;
endmodule

// File: doc/rx_fifo_arbiter.md
Name: rx_fifo_arbiter

Overview:
- Merges the 32-bit word streams of up to CHANNELS FE-I4 receiver channels into a single output FIFO/SRAM write stream.
- Each receiver channel presents FIFO_EMPTY, FIFO_DATA and FIFO_READ.
- Channels are served round-robin, with at most MAX_BURST words per grant, so that one busy front-end cannot starve the others.
- Words pass through unchanged; the 8-bit data header already identifies the source channel.

Parameters:
- CHANNELS, 4: number of receiver channels (1..16).
- MAX_BURST, 8: maximum words popped per grant (>=1; 0 is illegal).
- DSIZE, 32: word width.

Ports:
- BUS_CLK  input  1  the only clock; all logic on its rising edge.
- BUS_RST  input  1  synchronous, active-high reset.
- CHANNEL_EN  input  CHANNELS  per-channel enable; a disabled channel is never granted.
- RX_FIFO_EMPTY  input  CHANNELS  per-channel source FIFO empty flag.
- RX_FIFO_DATA  input  CHANNELS*DSIZE  per-channel head word. Channel i occupies bits [i*DSIZE +: DSIZE]. Sources are first-word-fall-through.
- RX_FIFO_READ  output  CHANNELS  per-channel pop strobe; combinational; at most one bit set.
- OUT_FIFO_FULL  input  1  downstream full flag.
- OUT_FIFO_WRITE  output  1  downstream write strobe.
- OUT_FIFO_DATA  output  DSIZE  downstream word.
- GRANT  output  CHANNELS  registered one-hot grant; all zero when idle.
- WORD_CNT  output  32  total words written downstream; wraps.

Behaviour:
- Reset (BUS_RST high at a clock edge):
  - state=IDLE, GRANT=0, burst_cnt=0, out_valid=0, OUT_FIFO_DATA=0, WORD_CNT=0.
  - last_grant=CHANNELS-1, so channel 0 has first priority.
  - A word held in the output register at reset is discarded.
- Output register (1 entry):
  - OUT_FIFO_WRITE = out_valid & ~OUT_FIFO_FULL.
  - can_accept = ~out_valid | ~OUT_FIFO_FULL.
  - On a pop: the register loads the popped word and out_valid=1.
  - On a write with no pop: out_valid=0.
  - WORD_CNT increments on every OUT_FIFO_WRITE cycle.
- State IDLE:
  - req[i] = ~RX_FIFO_EMPTY[i] & CHANNEL_EN[i].
  - If any req, pick the first requesting channel searching last_grant+1, last_grant+2, ..., modulo CHANNELS.
  - At the next edge: GRANT=onehot(sel), last_grant=sel, burst_cnt=0, go to SERVE.
  - No pops occur in IDLE.
- State SERVE (channel g):
  - RX_FIFO_READ[g] = ~RX_FIFO_EMPTY[g] & CHANNEL_EN[g] & (burst_cnt<MAX_BURST) & can_accept.
  - burst_cnt increments on each pop.
  - Go to IDLE (GRANT=0) when either:
    - RX_FIFO_EMPTY[g] or ~CHANNEL_EN[g] in the current cycle, with no pop; or
    - a pop makes burst_cnt reach MAX_BURST.
  - A stall caused only by OUT_FIFO_FULL keeps the arbiter in SERVE and holds the grant.
- Latency:
  - Request visible in IDLE at cycle t → GRANT at t+1, first pop at t+1, OUT_FIFO_WRITE at t+2 (if not full).
  - Sustained throughput is one word per cycle within a burst.
  - Re-arbitration costs one idle cycle: end of SERVE → IDLE → next grant.
- Disable mid-burst: pops stop in the same cycle CHANNEL_EN[g] falls. A word already in the output register is still written.
- A single active channel is re-granted after one IDLE cycle; there is no penalty beyond the gap.
- Arithmetic:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - The last_grant search wraps CHANNELS-1 → 0.
  - WORD_CNT wraps 0xFFFFFFFF → 0.

Test Plan:
- Reset, then load 3 words (0x01000001..3) into channel 1 only, OUT_FIFO_FULL=0 → GRANT=0b0010 one cycle after the request. Exactly 3 OUT_FIFO_WRITE pulses in order, data matches. Arbiter returns to IDLE and WORD_CNT=3.
- Channels 0 and 2 each hold 10 words, MAX_BURST=8 → output order is ch0 ×8, ch2 ×8, ch0 ×2, ch2 ×2. There is one idle cycle between bursts and WORD_CNT=20.
- Channel 3 served last, then channel 0 and channel 3 both request → channel 0 is granted first (wrap-around priority).
- OUT_FIFO_FULL held high for 5 cycles mid-burst → no RX_FIFO_READ while full and the held word is stable. GRANT is unchanged, and no word is lost or duplicated after release.
- CHANNEL_EN[1] dropped after 4 of 10 words → pops stop that cycle and 4 words are written. Channel 1 is never re-granted while disabled; re-enabling resumes at word 5.
- BUS_RST asserted mid-burst → the next cycle has GRANT=0, OUT_FIFO_WRITE=0 and WORD_CNT=0. After release, channel 0 wins over simultaneous requests.
